// File: rtl/calc_exec_unit.sv
// Calculator datapath: operand capture, one-cycle add/sub/xor and multi-cycle shift-add multiply.
// Define CALC_DIV_EN to add the MS=101 restoring divider. Otherwise MS=101 is reported as an invalid op.
module calc_exec_unit #(
  parameter int DATA_W = 8
) (
  input  logic                  CLK,
  input  logic                  clear_n,
  input  logic                  WE,
  input  logic                  W1,
  input  logic [DATA_W-1:0]     Din,
  input  logic [2:0]            MS,
  input  logic                  start,
  output logic [2*DATA_W-1:0]   result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  err,
  output logic                  neg,
  output logic                  zero
);

  localparam int RW = 2 * DATA_W;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int IW = $clog2(DATA_W);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
`ifdef CALC_DIV_EN
  localparam logic [2:0] OP_DIV = 3'b101;
  typedef enum logic [2:0] {IDLE, EXEC, MUL, DONE, DIV} state_t;
`else
  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     acc_q, acc_d;
  logic [RW-1:0]     res_q, res_d;
  logic              err_q, err_d, neg_q, neg_d, zero_q, zero_d;
  logic              start_d_q, arm_q, arm_d;
`ifdef CALC_DIV_EN
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [DATA_W:0]   rem_sh, rem_sub;
  logic              div_ge;
`endif

  logic                     req;
  logic [RW-1:0]            res_n;
  logic [RW-1:0]            add_w, xor_w, sub_w, mul_term;
  logic signed [DATA_W:0]   diff_w;

  // arm_q blocks a start level that was already high when reset released
  assign req      = start & ~start_d_q & arm_q;
  assign add_w    = {{DATA_W{1'b0}}, a_q} + {{DATA_W{1'b0}}, b_q};
  assign xor_w    = {{DATA_W{1'b0}}, a_q ^ b_q};
  assign diff_w   = $signed({1'b0, a_q}) - $signed({1'b0, b_q});
  assign sub_w    = {{(DATA_W-1){diff_w[DATA_W]}}, diff_w};
  assign mul_term = b_q[cnt_q[IW-1:0]] ? ({{DATA_W{1'b0}}, a_q} << cnt_q) : '0;
`ifdef CALC_DIV_EN
  assign rem_sh  = {rem_q, quo_q[DATA_W-1]};
  assign rem_sub = rem_sh - {1'b0, b_q};
  assign div_ge  = (rem_sh >= {1'b0, b_q});
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    err_d   = err_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    arm_d   = arm_q | ~start;
    res_n   = '0;
`ifdef CALC_DIV_EN
    rem_d   = rem_q;
    quo_d   = quo_q;
`endif
    case (state_q)
      IDLE: begin
        if (WE) begin
          if (W1) b_d = Din;
          else    a_d = Din;
        end
        if (req) begin
          op_d  = MS;
          cnt_d = '0;
          acc_d = '0;
`ifdef CALC_DIV_EN
          rem_d = '0;
          quo_d = a_d;
          if (MS == OP_DIV) state_d = DIV;
          else
`endif
          if (MS == OP_MUL) state_d = MUL;
          else              state_d = EXEC;
        end
      end
      EXEC: begin
        err_d = 1'b0;
        neg_d = 1'b0;
        case (op_q)
          OP_ADD: res_n = add_w;
          OP_SUB: begin
            res_n = sub_w;
            neg_d = sub_w[RW-1];
          end
          OP_XOR: res_n = xor_w;
          default: begin
            res_n = '0;
            err_d = 1'b1;
          end
        endcase
        res_d   = res_n;
        zero_d  = (res_n == '0);
        state_d = DONE;
      end
      // One multiplier bit per cycle; the extra cycle at cnt==DATA_W commits the product
      MUL: begin
        if (cnt_q == CW'(DATA_W)) begin
          res_d   = acc_q;
          zero_d  = (acc_q == '0);
          err_d   = 1'b0;
          neg_d   = 1'b0;
          state_d = DONE;
        end else begin
          acc_d = acc_q + mul_term;
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef CALC_DIV_EN
      DIV: begin
        neg_d = 1'b0;
        if (b_q == '0) begin
          res_d   = '1;
          zero_d  = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CW'(DATA_W)) begin
          res_d   = {rem_q, quo_q};
          zero_d  = ({rem_q, quo_q} == '0);
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          rem_d = div_ge ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], div_ge};
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      DONE: begin
        if (!start) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
      start_d_q <= 1'b0;
      arm_q     <= 1'b0;
`ifdef CALC_DIV_EN
      rem_q     <= '0;
      quo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      err_q     <= err_d;
      neg_q     <= neg_d;
      zero_q    <= zero_d;
      start_d_q <= start;
      arm_q     <= arm_d;
`ifdef CALC_DIV_EN
      rem_q     <= rem_d;
      quo_q     <= quo_d;
`endif
    end
  end

  assign result       = res_q;
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE) && (state_q != DONE);
  assign err          = err_q;
  assign neg          = neg_q;
  assign zero         = zero_q;

endmodule

// File: tb/tb_calc_exec_unit.sv
// Scoreboard bench for calc_exec_unit: directed ops push expectations, a monitor checks each result_valid rise.
module tb_calc_exec_unit;

  logic        CLK = 1'b0;
  logic        clear_n;
  logic        WE, W1, start;
  logic [7:0]  Din;
  logic [2:0]  MS;
  logic [15:0] result;
  logic        result_valid, busy, err, neg, zero;

  typedef struct {
    logic [15:0] res;
    logic        err;
    logic        neg;
    logic        zero;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   rises = 0;

  calc_exec_unit #(.DATA_W(8)) dut (
    .CLK(CLK), .clear_n(clear_n), .WE(WE), .W1(W1), .Din(Din), .MS(MS),
    .start(start), .result(result), .result_valid(result_valid),
    .busy(busy), .err(err), .neg(neg), .zero(zero)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Monitor: compare every new result against the oldest pending expectation
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (result_valid && !prev) begin
        rises++;
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 32'(result), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("err",    32'(err),    32'(e.err));
          chk("neg",    32'(neg),    32'(e.neg));
          chk("zero",   32'(zero),   32'(e.zero));
        end
      end
      prev = result_valid;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write(input logic w1, input logic [7:0] d);
    WE = 1'b1; W1 = w1; Din = d;
    tick();
    WE = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] ms, input logic [15:0] eres, input logic eerr,
                        input logic eneg, input int elat, input int ebusy, input int hold,
                        input bit wr_busy);
    exp_t e;
    int n;
    int nb;
    e.res = eres; e.err = eerr; e.neg = eneg; e.zero = (eres == 16'h0);
    sb_q.push_back(e);
    MS = ms; start = 1'b1; n = 0; nb = 0;
    while (!result_valid && n < 30) begin
      tick();
      n++;
      if (busy) nb++;
      if (wr_busy && n == 2) begin WE = 1'b1; W1 = 1'b0; Din = 8'h11; end
      if (wr_busy && n == 3) WE = 1'b0;
    end
    chk("latency", 32'(n), 32'(elat));
    chk("busy_cycles", 32'(nb), 32'(ebusy));
    repeat (hold) begin
      tick();
      chk("held_valid", 32'(result_valid), 32'd1);
    end
    start = 1'b0;
    tick();
    chk("valid_drop", 32'(result_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int nb;
    clear_n = 1'b0; WE = 1'b0; W1 = 1'b0; Din = 8'h00; MS = 3'b000; start = 1'b0;
    #17;
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_valid",  32'(result_valid), 32'h0);
    chk("rst_busy",   32'(busy), 32'h0);
    chk("rst_err",    32'(err), 32'h0);
    chk("rst_neg",    32'(neg), 32'h0);
    chk("rst_zero",   32'(zero), 32'h0);
    clear_n = 1'b1;
    tick();

    write(1'b0, 8'h05); write(1'b1, 8'h03);
    run_op(3'b001, 16'h0008, 1'b0, 1'b0, 2, 1, 0, 1'b0);
    write(1'b0, 8'hFF); write(1'b1, 8'h01);
    run_op(3'b001, 16'h0100, 1'b0, 1'b0, 2, 1, 0, 1'b0);
    write(1'b0, 8'h03); write(1'b1, 8'h05);
    run_op(3'b010, 16'hFFFE, 1'b0, 1'b1, 2, 1, 0, 1'b0);
    write(1'b0, 8'hAA); write(1'b1, 8'hAA);
    run_op(3'b100, 16'h0000, 1'b0, 1'b0, 2, 1, 0, 1'b0);
    write(1'b0, 8'hFF); write(1'b1, 8'hFF);
    run_op(3'b011, 16'hFE01, 1'b0, 1'b0, 10, 9, 0, 1'b1);
    run_op(3'b011, 16'hFE01, 1'b0, 1'b0, 10, 9, 0, 1'b0);

    // Abort a multiply with reset, then release reset while start is still high
    write(1'b0, 8'h12); write(1'b1, 8'h34);
    MS = 3'b011; start = 1'b1;
    repeat (4) tick();
    chk("mid_mul_busy", 32'(busy), 32'd1);
    clear_n = 1'b0;
    #1;
    chk("abort_result", 32'(result), 32'h0);
    chk("abort_busy",   32'(busy), 32'h0);
    chk("abort_valid",  32'(result_valid), 32'h0);
    tick();
    clear_n = 1'b1;
    r0 = rises; nb = 0;
    repeat (6) begin
      tick();
      if (busy) nb++;
    end
    chk("start_at_reset_busy", 32'(nb), 32'd0);
    chk("start_at_reset_ops", 32'(rises - r0), 32'd0);
    start = 1'b0;
    tick();
    run_op(3'b001, 16'h0000, 1'b0, 1'b0, 2, 1, 0, 1'b0);

    write(1'b0, 8'h5A); write(1'b1, 8'h33);
    r0 = rises;
    run_op(3'b110, 16'h0000, 1'b1, 1'b0, 2, 1, 4, 1'b0);
    chk("one_op_held_start", 32'(rises - r0), 32'd1);
    chk("err_cleared", 32'(err), 32'd0);

    write(1'b0, 8'h64); write(1'b1, 8'h07);
`ifdef CALC_DIV_EN
    run_op(3'b101, 16'h020E, 1'b0, 1'b0, 10, 9, 0, 1'b0);
    write(1'b1, 8'h00);
    run_op(3'b101, 16'hFFFF, 1'b1, 1'b0, 2, 1, 0, 1'b0);
`else
    run_op(3'b101, 16'h0000, 1'b1, 1'b0, 2, 1, 0, 1'b0);
`endif

    repeat (3) tick();
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
